// File: rtl/knn_local_sp_loader_if.sv
// Control, load-stream, buffer-port and replay-stream signals of the local search-space loader.
// master = the loader, slave = its surroundings (command source, load source, URAM, consumer).
interface knn_local_sp_loader_if #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11
);
    logic                    start;
    logic [AddressWidth:0]   num_words;
    logic [7:0]              num_passes;
    logic                    busy;
    logic                    done;

    logic [DataWidth-1:0]    in_data;
    logic                    in_valid;
    logic                    in_ready;

    logic [AddressWidth-1:0] mem_address0;
    logic                    mem_ce0;
    logic                    mem_we0;
    logic [DataWidth-1:0]    mem_d0;
    logic [DataWidth-1:0]    mem_q0;

    logic [DataWidth-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        input  start, num_words, num_passes, in_data, in_valid, mem_q0, out_ready,
        output busy, done, in_ready, mem_address0, mem_ce0, mem_we0, mem_d0,
               out_data, out_valid, out_last
    );

    modport slave (
        output start, num_words, num_passes, in_data, in_valid, mem_q0, out_ready,
        input  busy, done, in_ready, mem_address0, mem_ce0, mem_we0, mem_d0,
               out_data, out_valid, out_last
    );
endinterface

// File: rtl/knn_local_sp_loader.sv
// Fills the local search-space URAM from a stream, then replays it num_passes times; first word out ReadLatency+1 cycles into the sweep.
// Backpressure: reads are credit-gated so in-flight reads plus the 4-entry output FIFO never exceed 4; load side is ready throughout LOAD.
module knn_local_sp_loader #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    knn_local_sp_loader_if.master bus
);
    localparam int FifoDepth = 4;
    localparam int CntW      = AddressWidth + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_DRAIN, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         nw_q, nw_d;
    logic [7:0]              np_q, np_d;
    logic [CntW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [AddressWidth-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]              pass_q, pass_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    in_ready_q, in_ready_d;
    logic [ReadLatency-1:0]  trk_vld_q, trk_vld_d;
    logic [ReadLatency-1:0]  trk_last_q, trk_last_d;
    logic [DataWidth-1:0]    fifo_dat_q [FifoDepth];
    logic [DataWidth-1:0]    fifo_dat_d [FifoDepth];
    logic [FifoDepth-1:0]    fifo_last_q, fifo_last_d;
    logic [1:0]              fifo_wp_q, fifo_wp_d;
    logic [1:0]              fifo_rp_q, fifo_rp_d;
    logic [2:0]              fifo_cnt_q, fifo_cnt_d;

    logic            cmd_legal;
    logic            wr_hs;
    logic            issue;
    logic            rd_last;
    logic            pass_last;
    logic            push;
    logic            pop;
    logic [2:0]      inflight;
    logic [CntW-1:0] nw_last;

    assign cmd_legal = (bus.num_words != '0) && (bus.num_words <= CntW'(AddressRange));
    assign nw_last   = nw_q - CntW'(1);
    assign wr_hs     = (state_q == S_LOAD) && bus.in_valid;
    assign rd_last   = ({1'b0, rd_addr_q} == nw_last);
    assign pass_last = (pass_q == (np_q - 8'd1));
    assign push      = trk_vld_q[ReadLatency-1];
    assign pop       = (fifo_cnt_q != '0) && bus.out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            inflight = inflight + {2'b00, trk_vld_q[i]};
        end
    end

    // Credit: a read is only launched if its data is guaranteed a FIFO slot.
    assign issue = (state_q == S_SWEEP) && (({1'b0, fifo_cnt_q} + {1'b0, inflight}) < 4'd4);

    always_comb begin
        state_d   = state_q;
        nw_d      = nw_q;
        np_d      = np_q;
        wr_cnt_d  = wr_cnt_q;
        rd_addr_d = rd_addr_q;
        pass_d    = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cmd_legal) begin
                        state_d   = S_LOAD;
                        nw_d      = bus.num_words;
                        np_d      = bus.num_passes;
                        wr_cnt_d  = '0;
                        rd_addr_d = '0;
                        pass_d    = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (wr_hs) begin
                    wr_cnt_d = wr_cnt_q + CntW'(1);
                    if (wr_cnt_q == nw_last) begin
                        state_d = (np_q == 8'd0) ? S_DONE : S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                if (issue) begin
                    if (rd_last) begin
                        rd_addr_d = '0;
                        pass_d    = pass_q + 8'd1;
                        if (pass_last) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + AddressWidth'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && (fifo_cnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_LOAD) || (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d == S_LOAD);
    end

    // Read tracking: bit ReadLatency-1 lines up with mem_q0 being valid.
    always_comb begin
        trk_vld_d     = '0;
        trk_last_d    = '0;
        trk_vld_d[0]  = issue;
        trk_last_d[0] = issue && rd_last;
        for (int i = 1; i < ReadLatency; i++) begin
            trk_vld_d[i]  = trk_vld_q[i-1];
            trk_last_d[i] = trk_last_q[i-1];
        end
    end

    always_comb begin
        fifo_dat_d  = fifo_dat_q;
        fifo_last_d = fifo_last_q;
        fifo_wp_d   = fifo_wp_q;
        fifo_rp_d   = fifo_rp_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push) begin
            fifo_dat_d[fifo_wp_q]  = bus.mem_q0;
            fifo_last_d[fifo_wp_q] = trk_last_q[ReadLatency-1];
            fifo_wp_d              = fifo_wp_q + 2'd1;
        end
        if (pop) begin
            fifo_rp_d = fifo_rp_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nw_q        <= '0;
            np_q        <= '0;
            wr_cnt_q    <= '0;
            rd_addr_q   <= '0;
            pass_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            trk_vld_q   <= '0;
            trk_last_q  <= '0;
            fifo_last_q <= '0;
            fifo_wp_q   <= '0;
            fifo_rp_q   <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_dat_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            nw_q        <= nw_d;
            np_q        <= np_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            trk_vld_q   <= trk_vld_d;
            trk_last_q  <= trk_last_d;
            fifo_last_q <= fifo_last_d;
            fifo_wp_q   <= fifo_wp_d;
            fifo_rp_q   <= fifo_rp_d;
            fifo_cnt_q  <= fifo_cnt_d;
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_dat_q[i] <= fifo_dat_d[i];
            end
        end
    end

    // The buffer port is shared: load writes follow in_valid directly, sweep reads follow the credit check.
    always_comb begin
        bus.mem_ce0      = 1'b0;
        bus.mem_we0      = 1'b0;
        bus.mem_address0 = '0;
        bus.mem_d0       = '0;
        if (wr_hs) begin
            bus.mem_ce0      = 1'b1;
            bus.mem_we0      = 1'b1;
            bus.mem_address0 = wr_cnt_q[AddressWidth-1:0];
            bus.mem_d0       = bus.in_data;
        end else if (issue) begin
            bus.mem_ce0      = 1'b1;
            bus.mem_address0 = rd_addr_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (fifo_cnt_q != '0);
    assign bus.out_data  = fifo_dat_q[fifo_rp_q];
    assign bus.out_last  = (fifo_cnt_q != '0) && fifo_last_q[fifo_rp_q];
endmodule

// File: tb/tb_knn_local_sp_loader.sv
// Drives one loader with ReadLatency=1 and one with ReadLatency=2 from the same stimulus, each with its own URAM model.
module tb_knn_local_sp_loader;
    localparam int DW   = 256;
    localparam int AR   = 2048;
    localparam int AW   = 11;
    localparam int MAXO = 6144;

    typedef struct packed {
        int nw;
        int np;
        int exp_outs;
        int exp_wr;
        bit rnd;
        bit gaps;
        bit poke;
        bit stray;
        bit pat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready;
    logic          clr = 1'b0;
    logic          rdy_rand = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    num_passes = '0;
    logic [DW-1:0] in_data = '0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    logic [1:0]    ov_w, ol_w, ce_w, we_w, busy_w, done_w, inrdy_w;
    logic [DW-1:0] od_w [2];
    logic [DW-1:0] md_w [2];
    logic [AW-1:0] addr_w [2];

    int            wr_n [2], rd_n [2], pop_n [2], ce_n [2], viol [2], got_n [2];
    int            done_n [2], done_cyc [2], last_wr [2], first_ov [2], last_hs [2];
    logic [DW-1:0] got_dat [2][MAXO];
    logic          got_last [2][MAXO];
    logic [DW-1:0] wr_dat [2][AR];
    logic [AW-1:0] wr_addr [2][AR];
    logic [DW-1:0] dat [AR];

    for (genvar g = 0; g < 2; g++) begin : u
        knn_local_sp_loader_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();
        logic [DW-1:0] mem [AR];
        logic [DW-1:0] pipe [g+1];

        knn_local_sp_loader #(
            .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW), .ReadLatency(g + 1)
        ) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );

        assign bus.start      = start;
        assign bus.num_words  = num_words;
        assign bus.num_passes = num_passes;
        assign bus.in_data    = in_data;
        assign bus.in_valid   = in_valid;
        assign bus.out_ready  = out_ready;
        assign bus.mem_q0     = pipe[g];

        always @(posedge clk) begin
            if (bus.mem_ce0 && bus.mem_we0) mem[bus.mem_address0] <= bus.mem_d0;
            if (bus.mem_ce0 && !bus.mem_we0) pipe[0] <= mem[bus.mem_address0];
            for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
        end

        assign ov_w[g]    = bus.out_valid;
        assign ol_w[g]    = bus.out_last;
        assign ce_w[g]    = bus.mem_ce0;
        assign we_w[g]    = bus.mem_we0;
        assign busy_w[g]  = bus.busy;
        assign done_w[g]  = bus.done;
        assign inrdy_w[g] = bus.in_ready;
        assign od_w[g]    = bus.out_data;
        assign md_w[g]    = bus.mem_d0;
        assign addr_w[g]  = bus.mem_address0;
    end

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Port-level monitor: everything the checks need is observed from DUT pins only.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                wr_n[i] = 0; rd_n[i] = 0; pop_n[i] = 0; ce_n[i] = 0; viol[i] = 0; got_n[i] = 0;
                done_n[i] = 0; done_cyc[i] = -1; last_wr[i] = -1; first_ov[i] = -1; last_hs[i] = -1;
            end else begin
                if (ce_w[i]) ce_n[i]++;
                if (ce_w[i] && we_w[i]) begin
                    if (wr_n[i] < AR) begin
                        wr_addr[i][wr_n[i]] = addr_w[i];
                        wr_dat[i][wr_n[i]]  = md_w[i];
                    end
                    wr_n[i]++;
                    last_wr[i] = cyc;
                end
                if (ce_w[i] && !we_w[i]) rd_n[i]++;
                if (rd_n[i] - pop_n[i] > 4) viol[i]++;
                if (ov_w[i]) begin
                    if (first_ov[i] < 0) first_ov[i] = cyc;
                    if (out_ready) begin
                        if (got_n[i] < MAXO) begin
                            got_dat[i][got_n[i]]  = od_w[i];
                            got_last[i][got_n[i]] = ol_w[i];
                        end
                        got_n[i]++;
                        pop_n[i]++;
                        if (ol_w[i]) last_hs[i] = cyc;
                    end
                end
                if (done_w[i]) begin
                    done_n[i]++;
                    done_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            string t;
            t = $sformatf("%s rl%0d", tag, i + 1);
            chk({t, " busy"}, busy_w[i], 0);
            chk({t, " done"}, done_w[i], 0);
            chk({t, " in_ready"}, inrdy_w[i], 0);
            chk({t, " out_valid"}, ov_w[i], 0);
            chk({t, " out_last"}, ol_w[i], 0);
            chk({t, " out_data"}, od_w[i], 0);
            chk({t, " mem_ce0"}, ce_w[i], 0);
            chk({t, " mem_we0"}, we_w[i], 0);
            chk({t, " mem_address0"}, addr_w[i], 0);
            chk({t, " mem_d0"}, md_w[i], 0);
        end
    endtask

    task automatic fill(input int nw, input bit pat);
        for (int k = 0; k < nw && k < AR; k++) begin
            dat[k] = pat ? DW'(k + 160)
                         : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic start_and_load(input int nw, input int np, input bit gaps, input bit poke);
        int  k, guard, nload;
        bit  hs;
        nload = (nw >= 1 && nw <= AR) ? nw : 0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        start = 1'b1; num_words = (AW+1)'(nw); num_passes = 8'(np);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; guard = 0;
        while (k < nload && guard < 4 * AR) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = dat[k];
            if (poke && k == nload / 2) begin
                start = 1'b1; num_words = 1; num_passes = 0;
            end
            @(negedge clk);
            hs = in_valid && inrdy_w[0] && inrdy_w[1];
            @(posedge clk); #1;
            start = 1'b0; num_words = (AW+1)'(nw); num_passes = 8'(np);
            if (hs) k++;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input vec_t v);
        int guard, errs, idx;
        bit legal;
        legal = (v.nw >= 1) && (v.nw <= AR);
        rdy_rand = v.rnd;
        start_and_load(v.nw, v.np, v.gaps, v.poke);
        in_valid = v.stray;
        guard = 0;
        while (!(done_n[0] > 0 && done_n[1] > 0) && guard < 12000) begin
            in_data = {8{$urandom}};
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            string t;
            t = $sformatf("%s rl%0d", tag, i + 1);
            chk({t, " done pulses"}, done_n[i], 1);
            chk({t, " write count"}, wr_n[i], v.exp_wr);
            chk({t, " output count"}, got_n[i], v.exp_outs);
            errs = 0;
            for (int k = 0; k < wr_n[i] && k < AR; k++) begin
                if (wr_addr[i][k] !== AW'(k) || wr_dat[i][k] !== dat[k]) errs++;
            end
            chk({t, " write addr/data errors"}, errs, 0);
            errs = 0;
            if (legal) begin
                for (int j = 0; j < got_n[i] && j < MAXO; j++) begin
                    idx = j % v.nw;
                    if (got_dat[i][j] !== dat[idx] || got_last[i][j] !== (idx == v.nw - 1)) errs++;
                end
            end
            chk({t, " stream errors"}, errs, 0);
            chk({t, " credit violations"}, viol[i], 0);
            if (!legal) begin
                chk({t, " mem_ce0 activity"}, ce_n[i], 0);
            end else if (v.np == 0) begin
                chk({t, " done after last write"}, done_cyc[i] - last_wr[i], 1);
            end else begin
                chk({t, " first out_valid latency"}, first_ov[i] - last_wr[i], i + 3);
                chk({t, " done after last out_last"}, done_cyc[i] > last_hs[i], 1);
                if (!v.rnd) chk({t, " gapless replay span"}, last_hs[i] - first_ov[i] + 1, got_n[i]);
            end
        end
    endtask

    initial begin
        vec_t tbl [9];
        vec_t rv;
        int   guard;
        //         nw    np outs  wr   rnd   gaps  poke  stray pat
        tbl[0] = '{4,    1, 4,    4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{0,    3, 0,    0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2049, 1, 0,    0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3,    0, 0,    3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1,    5, 5,    1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{6,    2, 12,   6,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{2048, 3, 6144, 2048, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{37,   3, 111,  37,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2,    4, 8,    2,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 9; t++) begin
            fill(tbl[t].nw, tbl[t].pat);
            run_cmd($sformatf("vec%0d", t), tbl[t]);
        end

        for (int r = 0; r < 6; r++) begin
            rv.nw    = $urandom_range(1, 48);
            rv.np    = $urandom_range(0, 3);
            rv.exp_outs = rv.nw * rv.np;
            rv.exp_wr   = rv.nw;
            rv.rnd   = 1'b1;
            rv.gaps  = 1'($urandom_range(0, 1));
            rv.poke  = 1'b0;
            rv.stray = 1'($urandom_range(0, 1));
            rv.pat   = 1'b0;
            fill(rv.nw, 1'b0);
            run_cmd($sformatf("rand%0d", r), rv);
        end

        // Reset in the middle of a sweep, then a short fresh command.
        fill(8, 1'b0);
        start_and_load(8, 4, 1'b0, 1'b0);
        guard = 0;
        while (ov_w != 2'b11 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("midsweep reached replay", ov_w, 2'b11);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset("midsweep reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rv = '{2, 1, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fill(2, 1'b0);
        run_cmd("restart", rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
